instr_decode_pipe: RTL and testbench

//  Registered, handshaked decode stage between the IF/ID and ID/EX pipeline registers.
//  - Decodes the 32-bit instruction into the full control bundle.
//  - Tracks in-flight destination registers in a scoreboard and stalls RAW hazards.
//  - Latches HALT and stops accepting instructions until flushed.

---
 rtl/instr_decode_pipe.sv | 162 ++++++++++++++++
 tb/tb_instr_decode_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: registered, handshaked decode stage with RAW scoreboard and HALT latch.
// Optional macro SCOREBOARD_EN adds the scoreboard and hazard stall; without it hazards are resolved downstream.
// Opcodes: ADD 0 SUB 1 ADDi 2 SUBi 3 AND 4 OR 5 NOR 6 SLL 7 SRL 8 SRA 9 LW 10 SW 11 MOV 12 MOVi 13
//          B 14 JR 15 JAL 16 ACT 17 LD 18 MAP 19 RD 20 CORD 21 KEY 22 TM 23 HALT 24; 25-31 are NOPs.
module instr_decode_pipe #(
  parameter int REG_AW = 5,
  parameter int IMM_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [REG_AW-1:0] out_dst,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [IMM_W-1:0]  out_imm,
  output logic [11:0]       out_ctl,
  output logic              out_ior,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic              flush,
  output logic              stall_raw,
  output logic              halted
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_ADDI = 5'd2,  OP_SUBI = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_NOR  = 5'd6,  OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_LW   = 5'd10, OP_SW   = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12, OP_MOVI = 5'd13, OP_B    = 5'd14, OP_JR   = 5'd15;
  localparam logic [4:0] OP_JAL  = 5'd16, OP_ACT  = 5'd17, OP_LD   = 5'd18, OP_MAP  = 5'd19;
  localparam logic [4:0] OP_RD   = 5'd20, OP_CORD = 5'd21, OP_KEY  = 5'd22, OP_HALT = 5'd24;

  // Bit positions inside the 13-bit decode word {ior, out_ctl}
  localparam int B_IOR = 12, B_IMM = 11, B_DST = 10, B_RES = 9, B_RET = 8, B_BR = 7;
  localparam int B_SGN = 6, B_NEG = 5, B_CRY = 4, B_OVF = 3, B_ZR = 2, B_SRE = 1, B_SWE = 0;

  function automatic logic [12:0] decode_ctl(input logic [4:0] op);
    logic [12:0] c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB: begin c[B_RES] = 1'b1; c[B_RET] = 1'b1; c[B_DST] = 1'b1; end
      OP_ADDI, OP_MOVI: begin c[B_RES] = 1'b1; c[B_IMM] = 1'b1; c[B_DST] = 1'b1; end
      OP_SUBI: begin
        c[B_RES] = 1'b1; c[B_IMM] = 1'b1; c[B_DST] = 1'b1;
        c[B_SGN] = 1'b1; c[B_NEG] = 1'b1; c[B_CRY] = 1'b1; c[B_OVF] = 1'b1; c[B_ZR] = 1'b1;
      end
      OP_AND, OP_OR, OP_NOR: begin
        c[B_RES] = 1'b1; c[B_RET] = 1'b1; c[B_DST] = 1'b1; c[B_ZR] = 1'b1;
      end
      OP_SLL: begin
        c[B_RES] = 1'b1; c[B_IMM] = 1'b1; c[B_DST] = 1'b1; c[B_ZR] = 1'b1; c[B_OVF] = 1'b1;
      end
      OP_SRL, OP_SRA: begin c[B_RES] = 1'b1; c[B_IMM] = 1'b1; c[B_DST] = 1'b1; c[B_ZR] = 1'b1; end
      OP_LW, OP_MOV: begin c[B_RES] = 1'b1; c[B_DST] = 1'b1; end
      OP_SW:   c[B_RES] = 1'b1;
      OP_B:    begin c[B_IMM] = 1'b1; c[B_BR] = 1'b1; end
      OP_JR:   begin c[B_RES] = 1'b1; c[B_BR] = 1'b1; end
      OP_JAL:  begin c[B_IMM] = 1'b1; c[B_DST] = 1'b1; c[B_BR] = 1'b1; end
      OP_ACT, OP_LD, OP_MAP: c[B_SWE] = 1'b1;
      OP_RD, OP_CORD: begin c[B_SRE] = 1'b1; c[B_DST] = 1'b1; end
      OP_KEY:  c[B_IOR] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Stage p0: combinational decode of the incoming instruction
  logic [4:0]        op_p0;
  logic [REG_AW-1:0] dst_p0, rs_p0, rt_p0;
  logic [IMM_W-1:0]  imm_p0;
  logic [12:0]       ctl_p0;
  logic              hazard_p0, accept_p0;

  assign op_p0  = instr[31:27];
  assign dst_p0 = instr[22 +: REG_AW];
  assign rs_p0  = instr[17 +: REG_AW];
  assign rt_p0  = instr[12 +: REG_AW];
  assign imm_p0 = instr[IMM_W-1:0];
  assign ctl_p0 = decode_ctl(op_p0);

  logic              vld_p1;
  logic [4:0]        op_p1;
  logic [REG_AW-1:0] dst_p1, rs_p1, rt_p1;
  logic [IMM_W-1:0]  imm_p1;
  logic [11:0]       ctl_p1;
  logic              ior_p1;
  logic              halted_q;

  assign in_ready  = !halted_q && !hazard_p0 && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready && !flush;
  assign stall_raw = in_valid && hazard_p0;

`ifdef SCOREBOARD_EN
  localparam int SB_N = 1 << REG_AW;
  logic [SB_N-1:0] sb_q, sb_set, sb_clr;

  // Hazard reads the registered scoreboard, so a same-cycle writeback releases the stall one cycle later
  assign hazard_p0 = (ctl_p0[B_RES] && sb_q[rs_p0]) || (ctl_p0[B_RET] && sb_q[rt_p0]);

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (accept_p0 && ctl_p0[B_DST] && (dst_p0 != '0)) sb_set[dst_p0] = 1'b1;
    if (wb_valid) sb_clr[wb_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sb_q <= '0;
    else if (flush) sb_q <= '0;
    else            sb_q <= (sb_q & ~sb_clr) | sb_set;
  end
`else
  logic unused_wb;
  assign hazard_p0 = 1'b0;
  assign unused_wb = ^{wb_valid, wb_reg};
`endif

  // Stage p1: output register, held while EX back-pressures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      op_p1    <= '0;
      dst_p1   <= '0;
      rs_p1    <= '0;
      rt_p1    <= '0;
      imm_p1   <= '0;
      ctl_p1   <= '0;
      ior_p1   <= 1'b0;
      halted_q <= 1'b0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (!vld_p1 || out_ready) vld_p1 <= accept_p0;
      if (accept_p0) begin
        op_p1  <= op_p0;
        dst_p1 <= dst_p0;
        rs_p1  <= rs_p0;
        rt_p1  <= rt_p0;
        imm_p1 <= imm_p0;
        ctl_p1 <= ctl_p0[11:0];
        ior_p1 <= ctl_p0[B_IOR];
        if (op_p0 == OP_HALT) halted_q <= 1'b1;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_opcode = op_p1;
  assign out_dst    = dst_p1;
  assign out_rs     = rs_p1;
  assign out_rt     = rt_p1;
  assign out_imm    = imm_p1;
  assign out_ctl    = ctl_p1;
  assign out_ior    = ior_p1;
  assign halted     = halted_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Self-checking bench for instr_decode_pipe: directed scenarios plus randomized traffic
// against a transaction-level model (decode table, pending-register set, halt flag).
`timescale 1ns/1ps
module tb_instr_decode_pipe;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 17;
`ifdef SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif
  // With the scoreboard the dependent ADD stalls; without it it goes straight through
  localparam logic [31:0] T2_RDY   = SB_EN ? 32'd0 : 32'd1;
  localparam logic [31:0] T2_STALL = SB_EN ? 32'd1 : 32'd0;

  localparam logic [4:0] ADD = 5'd0, ADDI = 5'd2, SUBI = 5'd3, SW = 5'd11, MOV = 5'd12;
  localparam logic [4:0] KEY = 5'd22, HALT = 5'd24;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_ior;
  logic wb_valid, flush, stall_raw, halted;
  logic [31:0] instr;
  logic [4:0] out_opcode;
  logic [REG_AW-1:0] out_dst, out_rs, out_rt, wb_reg;
  logic [IMM_W-1:0] out_imm;
  logic [11:0] out_ctl;

  always #5 clk = ~clk;

  instr_decode_pipe #(.REG_AW(REG_AW), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_dst(out_dst), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
    .out_ctl(out_ctl), .out_ior(out_ior), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .stall_raw(stall_raw), .halted(halted)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Decode table {ior, use_imm,use_dst,reS,reT,branch,sign,neg,carry,ovf,zero,sprite_re,sprite_we}
  logic [12:0] ctl_tab [32];

  bit          m_vld, m_halted;
  bit   [31:0] m_pend;
  logic [4:0]  m_op, m_dst, m_rs, m_rt;
  logic [16:0] m_imm;
  logic [12:0] m_ctl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [4:0] d,
                                       input logic [4:0] s, input logic [4:0] t);
    return {op, d, s, t, 12'h000};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] d,
                                       input logic [4:0] s, input logic [16:0] imm);
    return {op, d, s, imm};
  endfunction

  function automatic bit m_hazard();
    logic [12:0] c;
    c = ctl_tab[instr[31:27]];
    return SB_EN && ((c[9] && m_pend[instr[21:17]]) || (c[8] && m_pend[instr[16:12]]));
  endfunction

  function automatic bit m_ready();
    return !m_halted && !m_hazard() && (!m_vld || out_ready);
  endfunction

  task automatic m_reset();
    m_vld = 0; m_halted = 0; m_pend = '0;
    m_op = '0; m_dst = '0; m_rs = '0; m_rt = '0; m_imm = '0; m_ctl = '0;
  endtask

  task automatic set_in(input bit v, input logic [31:0] ins, input bit ordy,
                        input bit wbv, input logic [4:0] wbr, input bit fl);
    in_valid = v; instr = ins; out_ready = ordy; wb_valid = wbv; wb_reg = wbr; flush = fl;
  endtask

  task automatic compare();
    bit h;
    h = m_hazard();
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("stall_raw", 32'(stall_raw), 32'(in_valid && h));
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("halted", 32'(halted), 32'(m_halted));
    if (m_vld) begin
      chk("out_opcode", 32'(out_opcode), 32'(m_op));
      chk("out_dst", 32'(out_dst), 32'(m_dst));
      chk("out_rs", 32'(out_rs), 32'(m_rs));
      chk("out_rt", 32'(out_rt), 32'(m_rt));
      chk("out_imm", 32'(out_imm), 32'(m_imm));
      chk("out_ctl", 32'(out_ctl), 32'(m_ctl[11:0]));
      chk("out_ior", 32'(out_ior), 32'(m_ctl[12]));
    end
  endtask

  // One clock: check the DUT against the model, then advance the model over the edge
  task automatic cycle();
    bit acc;
    #1;
    compare();
    @(posedge clk);
    acc = in_valid && m_ready() && !flush;
    if (flush) begin
      m_vld = 0; m_pend = '0; m_halted = 0;
    end else begin
      if (!m_vld || out_ready) m_vld = acc;
      if (wb_valid) m_pend[wb_reg] = 1'b0;
      if (acc) begin
        m_op = instr[31:27]; m_dst = instr[26:22]; m_rs = instr[21:17];
        m_rt = instr[16:12]; m_imm = instr[16:0]; m_ctl = ctl_tab[instr[31:27]];
        if (m_ctl[10] && instr[26:22] != 5'd0) m_pend[instr[26:22]] = 1'b1;
        if (instr[31:27] == HALT) m_halted = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ctl_tab[i] = 13'h0000;
    ctl_tab[0]  = 13'h0700; ctl_tab[1]  = 13'h0700;                          // ADD SUB
    ctl_tab[2]  = 13'h0E00; ctl_tab[3]  = 13'h0E7C;                          // ADDi SUBi
    ctl_tab[4]  = 13'h0704; ctl_tab[5]  = 13'h0704; ctl_tab[6] = 13'h0704;   // AND OR NOR
    ctl_tab[7]  = 13'h0E0C; ctl_tab[8]  = 13'h0E04; ctl_tab[9] = 13'h0E04;   // SLL SRL SRA
    ctl_tab[10] = 13'h0600; ctl_tab[11] = 13'h0200;                          // LW SW
    ctl_tab[12] = 13'h0600; ctl_tab[13] = 13'h0E00;                          // MOV MOVi
    ctl_tab[14] = 13'h0880; ctl_tab[15] = 13'h0280; ctl_tab[16] = 13'h0C80;  // B JR JAL
    ctl_tab[17] = 13'h0001; ctl_tab[18] = 13'h0001; ctl_tab[19] = 13'h0001;  // ACT LD MAP
    ctl_tab[20] = 13'h0402; ctl_tab[21] = 13'h0402; ctl_tab[22] = 13'h1000;  // RD CORD KEY

    rst = 1'b1;
    set_in(0, 32'h0, 0, 0, 5'd0, 0);
    m_reset();
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall_raw", 32'(stall_raw), 32'd0);
    chk("rst_out_bundle", {out_opcode, out_dst, out_rs, out_rt, out_ior}, 32'd0);
    chk("rst_out_imm_ctl", {3'b0, out_imm, out_ctl}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADDi r3,r1,#5
    set_in(1, mk_i(ADDI, 5'd3, 5'd1, 17'd5), 1, 0, 5'd0, 0);
    cycle();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_dst", 32'(out_dst), 32'd3);
    chk("t1_out_imm", 32'(out_imm), 32'd5);
    chk("t1_out_ctl", 32'(out_ctl), 32'hE00);
    set_in(0, 32'h0, 1, 0, 5'd0, 0);
    cycle();

    // ADD r4,r1,r2 then dependent ADD r5,r4,r1
    set_in(1, mk_r(ADD, 5'd4, 5'd1, 5'd2), 1, 0, 5'd0, 0);
    cycle();
    set_in(1, mk_r(ADD, 5'd5, 5'd4, 5'd1), 1, 0, 5'd0, 0);
    #1;
    chk("t2_in_ready_dep", 32'(in_ready), T2_RDY);
    chk("t2_stall_raw", 32'(stall_raw), T2_STALL);
    cycle();
    set_in(1, mk_r(ADD, 5'd5, 5'd4, 5'd1), 1, 1, 5'd4, 0);
    #1;
    chk("t2_in_ready_wb_cycle", 32'(in_ready), T2_RDY);
    cycle();
    set_in(1, mk_r(ADD, 5'd5, 5'd4, 5'd1), 1, 0, 5'd0, 0);
    #1;
    chk("t2_in_ready_release", 32'(in_ready), 32'd1);
    cycle();
    chk("t2_out_dst", 32'(out_dst), 32'd5);
    set_in(0, 32'h0, 1, 0, 5'd0, 0);
    cycle();

    // Back-pressure hold
    set_in(1, mk_r(MOV, 5'd2, 5'd1, 5'd0), 1, 0, 5'd0, 0);
    cycle();
    set_in(1, mk_r(SW, 5'd0, 5'd0, 5'd0), 0, 0, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_in_ready_hold", 32'(in_ready), 32'd0);
      chk("t3_out_valid_hold", 32'(out_valid), 32'd1);
      chk("t3_out_dst_hold", 32'(out_dst), 32'd2);
      chk("t3_out_opcode_hold", 32'(out_opcode), 32'(MOV));
      cycle();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_release", 32'(in_ready), 32'd1);
    cycle();
    chk("t3_out_opcode_next", 32'(out_opcode), 32'(SW));

    // HALT, then flush with an instruction presented
    set_in(1, mk_r(HALT, 5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 0);
    #1;
    chk("t4_halt_accept", 32'(in_ready), 32'd1);
    cycle();
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_halt_bundle", {out_valid, out_opcode, out_ior, out_ctl}, {13'h0, 1'b1, HALT, 1'b0, 12'h000});
    set_in(1, mk_r(ADD, 5'd1, 5'd0, 5'd0), 1, 0, 5'd0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t4_in_ready_halted", 32'(in_ready), 32'd0);
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    chk("t4_flush_halted", 32'(halted), 32'd0);
    chk("t4_flush_out_valid", 32'(out_valid), 32'd0);
    chk("t4_flush_in_ready", 32'(in_ready), 32'd1);
    cycle();

    // SUBi r2,r2,#1 then KEY
    set_in(1, mk_i(SUBI, 5'd2, 5'd2, 17'd1), 1, 0, 5'd0, 0);
    cycle();
    chk("t5_upd_flags", 32'(out_ctl[6:2]), 32'h1F);
    chk("t5_subi_ctl", 32'(out_ctl), 32'hE7C);
    set_in(1, mk_r(KEY, 5'd0, 5'd0, 5'd0), 1, 0, 5'd0, 0);
    cycle();
    chk("t5_key_ior", 32'(out_ior), 32'd1);
    chk("t5_key_ctl", 32'(out_ctl), 32'd0);

    // Asynchronous reset while a bundle is held and r7 is pending
    set_in(1, mk_r(MOV, 5'd7, 5'd0, 5'd0), 1, 0, 5'd0, 0);
    cycle();
    set_in(0, 32'h0, 0, 0, 5'd0, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    m_reset();
    set_in(1, mk_r(ADD, 5'd1, 5'd7, 5'd7), 1, 0, 5'd0, 0);
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_stall_raw", 32'(stall_raw), 32'd0);
    cycle();
    chk("t6_out_valid", 32'(out_valid), 32'd1);
    chk("t6_out_rs", 32'(out_rs), 32'd7);

    // Randomized traffic on a small register set to provoke hazards
    for (int i = 0; i < 800; i++) begin
      logic [4:0] op;
      logic [31:0] ins;
      op  = 5'($urandom_range(0, 31));
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 12'($urandom)};
      set_in(($urandom % 100) < 80, ins, ($urandom % 100) < 70,
             ($urandom % 100) < 30, 5'($urandom_range(0, 7)), ($urandom % 100) < 4);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
